urv_imem_bridge: RTL and testbench

URV_IMEM_BRIDGE -- requirements
Module: urv_imem_bridge

---
 rtl/urv_imem_bridge.sv | 129 ++++++++++++
 tb/tb_urv_imem_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_imem_bridge.sv
// urv_imem_bridge: prefetching instruction-fetch bridge onto a pipelined Wishbone-style read bus.
// Define URV_IMEM_ERR_EN to add the ib_err_i / im_err_o bus-error path.
module urv_imem_bridge #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
`ifdef URV_IMEM_ERR_EN
  output logic        im_err_o,
  input  logic        ib_err_i,
`endif
  output logic        ib_cyc_o,
  output logic        ib_stb_o,
  output logic [31:0] ib_adr_o,
  input  logic        ib_stall_i,
  input  logic        ib_ack_i,
  input  logic [31:0] ib_dat_i
);

  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  logic [31:0] r_cur_addr;
  logic [31:0] r_pf_addr;
  logic [31:0] r_ack_tag;
  logic [2:0]  r_count;
  logic [2:0]  r_outstanding;
  logic [2:0]  r_discard;
  logic [31:0] r_q_tag  [DEPTH];
  logic [31:0] r_q_data [DEPTH];
`ifdef URV_IMEM_ERR_EN
  logic        r_q_err  [DEPTH];
`endif

  logic        w_seq;
  logic        w_hold;
  logic        w_redirect;
  logic        w_accept;
  logic        w_term;
  logic        w_term_err;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_wr_idx;
  logic [3:0]  w_used;

  assign im_valid_o = (r_count != 3'd0) && (r_q_tag[0] == r_cur_addr);
  assign im_data_o  = r_q_data[0];

  // Fetch-stage intent: step to the next word only when the current one was delivered.
  assign w_seq      = (im_addr_i == r_cur_addr + 32'd4) && im_valid_o;
  assign w_hold     = (im_addr_i == r_cur_addr);
  assign w_redirect = !w_seq && !w_hold;

  assign w_used   = {1'b0, r_count} + {1'b0, r_outstanding};
  assign ib_stb_o = !w_redirect && (w_used < DEPTH_W);
  assign ib_adr_o = r_pf_addr;
  assign ib_cyc_o = ib_stb_o || (r_outstanding != 3'd0);
  assign w_accept = ib_stb_o && !ib_stall_i;

`ifdef URV_IMEM_ERR_EN
  assign w_term     = ib_cyc_o && (ib_ack_i || ib_err_i);
  assign w_term_err = ib_err_i;
  assign im_err_o   = im_valid_o && r_q_err[0];
`else
  assign w_term     = ib_cyc_o && ib_ack_i;
  assign w_term_err = 1'b0;
`endif

  // Responses for reads issued before a redirect are swallowed via r_discard.
  assign w_pop    = w_seq;
  assign w_push   = !w_redirect && w_term && (r_discard == 3'd0);
  assign w_wr_idx = w_pop ? (r_count - 3'd1) : r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cur_addr    <= 32'd0;
      r_pf_addr     <= 32'd0;
      r_ack_tag     <= 32'd0;
      r_count       <= 3'd0;
      r_outstanding <= 3'd0;
      r_discard     <= 3'd0;
    end else begin
      r_cur_addr <= im_addr_i;
      if (w_redirect) begin
        r_pf_addr     <= im_addr_i;
        r_ack_tag     <= im_addr_i;
        r_count       <= 3'd0;
        r_discard     <= r_outstanding - {2'b00, w_term};
        r_outstanding <= r_outstanding - {2'b00, w_term};
      end else begin
        if (w_accept) r_pf_addr <= r_pf_addr + 32'd4;
        if (w_push)   r_ack_tag <= r_ack_tag + 32'd4;
        if (w_term && (r_discard != 3'd0)) r_discard <= r_discard - 3'd1;

        if (w_push && !w_pop)      r_count <= r_count + 3'd1;
        else if (w_pop && !w_push) r_count <= r_count - 3'd1;

        if (w_accept && !w_term)      r_outstanding <= r_outstanding + 3'd1;
        else if (w_term && !w_accept) r_outstanding <= r_outstanding - 3'd1;
      end
    end
  end

  // NOTE: queue storage has no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_pop) begin
        r_q_tag[i]  <= r_q_tag[i+1];
        r_q_data[i] <= r_q_data[i+1];
`ifdef URV_IMEM_ERR_EN
        r_q_err[i]  <= r_q_err[i+1];
`endif
      end
    end
    // NOTE: this write follows the shift, so the later non-blocking assignment wins on a shared slot.
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (w_wr_idx == 3'(i))) begin
        r_q_tag[i]  <= r_ack_tag;
        r_q_data[i] <= ib_dat_i;
`ifdef URV_IMEM_ERR_EN
        r_q_err[i]  <= w_term_err;
`endif
      end
    end
  end

endmodule

// File: tb/tb_urv_imem_bridge.sv
// tb_urv_imem_bridge: directed + randomized bench for urv_imem_bridge against a queue-based reference model.
// The model tracks the prefetch queue, in-flight reads and the address stream; a bus responder supplies acks.
module tb_urv_imem_bridge;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic        ib_cyc_o;
  logic        ib_stb_o;
  logic [31:0] ib_adr_o;
  logic        ib_stall_i;
  logic        ib_ack_i;
  logic [31:0] ib_dat_i;
`ifdef URV_IMEM_ERR_EN
  logic        im_err_o;
`endif

  always #5 clk = ~clk;

  urv_imem_bridge #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .im_addr_i  (im_addr_i),
    .im_data_o  (im_data_o),
    .im_valid_o (im_valid_o),
`ifdef URV_IMEM_ERR_EN
    .im_err_o   (im_err_o),
    .ib_err_i   (1'b0),
`endif
    .ib_cyc_o   (ib_cyc_o),
    .ib_stb_o   (ib_stb_o),
    .ib_adr_o   (ib_adr_o),
    .ib_stall_i (ib_stall_i),
    .ib_ack_i   (ib_ack_i),
    .ib_dat_i   (ib_dat_i)
  );

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] data;
  } entry_t;

  // Reference model state
  entry_t      mq[$];
  logic [31:0] m_cur = 32'd0;
  logic [31:0] m_pf = 32'd0;
  logic [31:0] m_ack_tag = 32'd0;
  int          m_out = 0;
  int          m_disc = 0;

  // Bus responder and scoreboard
  logic [31:0] pend[$];
  logic [31:0] issued[$];
  int          data_sel = 0;
  int          ack_pct = 100;
  int          stall_pct = 0;
  bit          force_stall = 1'b0;

  // Observations from the most recent step
  logic        s_valid;
  logic        s_stb;
  logic        s_cyc;
  logic [31:0] s_data;
  logic [31:0] s_adr;
  logic [31:0] s_cur;

  int n_assert = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (data_sel == 0)      return 32'h0000_0013;
    else if (data_sel == 1) return a;
    else                    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock cycle. mode 0: drive cmd; mode 1: behave like a fetch stage (advance when valid, else hold).
  task automatic step(input int mode, input logic [31:0] cmd, input bit rst, input bit stray);
    logic        mv, seq, hold, redir, mstb, mcyc, term, stall, ack, acc_dut;
    logic [31:0] addr, dat;
    entry_t      e;

    if (stray) begin
      ack = 1'b1;
      dat = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && $urandom_range(99) < ack_pct) begin
      ack = 1'b1;
      dat = mem(pend[0]);
    end else begin
      ack = 1'b0;
      dat = $urandom;
    end
    stall = force_stall || ($urandom_range(99) < stall_pct);

    mv    = (mq.size() > 0) && (mq[0].tag == m_cur);
    addr  = (mode == 1) ? (mv ? m_cur + 32'd4 : m_cur) : cmd;
    seq   = (addr == m_cur + 32'd4) && mv;
    hold  = (addr == m_cur);
    redir = !seq && !hold;
    mstb  = !redir && (mq.size() + m_out < DEPTH);
    mcyc  = mstb || (m_out != 0);
    term  = ack && mcyc;

    rst_n_i    = !rst;
    im_addr_i  = addr;
    ib_ack_i   = ack;
    ib_dat_i   = dat;
    ib_stall_i = stall;
    #1;
    s_valid = im_valid_o;
    s_data  = im_data_o;
    s_stb   = ib_stb_o;
    s_cyc   = ib_cyc_o;
    s_adr   = ib_adr_o;
    s_cur   = m_cur;
    acc_dut = ib_cyc_o && ib_stb_o && !stall;

    if (!rst) begin
      check("im_valid", {31'd0, im_valid_o}, {31'd0, mv});
      if (mv) check("im_data", im_data_o, mq[0].data);
      check("ib_stb", {31'd0, ib_stb_o}, {31'd0, mstb});
      check("ib_cyc", {31'd0, ib_cyc_o}, {31'd0, mcyc});
      if (mstb) check("ib_adr", ib_adr_o, m_pf);
    end

    @(posedge clk);
    if (rst) begin
      mq.delete();
      pend.delete();
      m_cur = 32'd0; m_pf = 32'd0; m_ack_tag = 32'd0; m_out = 0; m_disc = 0;
    end else begin
      if (ack && !stray && pend.size() > 0) void'(pend.pop_front());
      if (acc_dut === 1'b1) pend.push_back(s_adr);
      if (redir) begin
        mq.delete();
        m_pf = addr;
        m_ack_tag = addr;
        if (term) m_out--;
        m_disc = m_out;
      end else begin
        if (seq) void'(mq.pop_front());
        if (term) begin
          if (m_disc > 0) m_disc--;
          else begin
            e.tag = m_ack_tag;
            e.data = dat;
            mq.push_back(e);
            m_ack_tag += 32'd4;
          end
        end
        if (mstb && !stall) begin
          issued.push_back(m_pf);
          m_pf += 32'd4;
          m_out++;
        end
        if (term) m_out--;
      end
      m_cur = addr;
      check("outstanding_le_depth", {31'd0, pend.size() <= DEPTH}, 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    int first_v;
    int gaps;
    bit seen;

    rst_n_i = 1'b0; im_addr_i = 32'd0; ib_ack_i = 1'b0; ib_dat_i = 32'd0; ib_stall_i = 1'b0;
    @(negedge clk);
    step(0, 32'd0, 1'b1, 1'b0);
    step(0, 32'd0, 1'b1, 1'b0);

    // Hold at 0 after reset: 0 then 4 issued, valid 0x13 within 3 cycles
    data_sel = 0; ack_pct = 100; stall_pct = 0;
    issued.delete();
    first_v = -1;
    for (int i = 0; i < 6; i++) begin
      step(0, 32'd0, 1'b0, 1'b0);
      if (i == 0) check("reset_valid_low", {31'd0, s_valid}, 32'd0);
      if (s_valid && first_v < 0) begin
        first_v = i;
        check("first_word_data", s_data, 32'h0000_0013);
      end
    end
    check("first_valid_by_cycle3", {31'd0, (first_v >= 0) && (first_v <= 3)}, 32'd1);
    check("first_issue", issued[0], 32'h0000_0000);
    check("second_issue", issued[1], 32'h0000_0004);
    // Queue full and idle bus: a stray ack must not be taken
    check("idle_cyc_low", {31'd0, s_cyc}, 32'd0);
    step(0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1, 32'd0, 1'b0, 1'b0);

    // Sequential stream with data == address
    data_sel = 1;
    step(0, 32'h0000_0040, 1'b0, 1'b0);
    seen = 1'b0; gaps = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 32'd0, 1'b0, 1'b0);
      if (s_valid) begin
        seen = 1'b1;
        check("seq_data_eq_addr", s_data, s_cur);
      end else if (seen) gaps++;
    end
    check("seq_stream_started", {31'd0, seen}, 32'd1);
    check("seq_no_gaps", gaps, 32'd0);

    // Redirect to 0x100 with two reads in flight
    data_sel = 2;
    step(0, 32'h0000_0080, 1'b0, 1'b0);
    ack_pct = 0;
    step(0, 32'h0000_0080, 1'b0, 1'b0);
    step(0, 32'h0000_0080, 1'b0, 1'b0);
    check("two_in_flight", pend.size(), 32'd2);
    issued.delete();
    step(0, 32'h0000_0100, 1'b0, 1'b0);
    check("redirect_stb_low", {31'd0, s_stb}, 32'd0);
    ack_pct = 100;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(0, 32'h0000_0100, 1'b0, 1'b0);
      if (i == 0) check("redirect_issue_next", s_adr, 32'h0000_0100);
      if (s_valid && !seen) begin
        seen = 1'b1;
        check("redirect_first_tag", s_cur, 32'h0000_0100);
        check("redirect_first_data", s_data, mem(32'h0000_0100));
      end
    end
    check("redirect_valid_seen", {31'd0, seen}, 32'd1);
    check("redirect_first_issued", issued[0], 32'h0000_0100);

    // Stall for 5 cycles: address holds, nothing issued twice
    issued.delete();
    force_stall = 1'b1;
    step(0, 32'h0000_0300, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 32'h0000_0300, 1'b0, 1'b0);
      check("stall_adr_hold", s_adr, 32'h0000_0300);
    end
    check("stall_nothing_accepted", issued.size(), 32'd0);
    force_stall = 1'b0;
    for (int i = 0; i < 10; i++) step(1, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < issued.size(); k++)
      check("stall_issue_order", issued[k], 32'h0000_0300 + 32'(4 * k));

    // Wrap at the top of the address space
    data_sel = 1;
    issued.delete();
    step(0, 32'hFFFF_FFF8, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'd0, 1'b0, 1'b0);
      if (s_valid) check("wrap_data_eq_addr", s_data, s_cur);
    end
    check("wrap_issue0", issued[0], 32'hFFFF_FFF8);
    check("wrap_issue1", issued[1], 32'hFFFF_FFFC);
    check("wrap_issue2", issued[2], 32'h0000_0000);

    // Reset with two reads outstanding
    step(0, 32'h0000_0500, 1'b0, 1'b0);
    ack_pct = 0;
    step(0, 32'h0000_0500, 1'b0, 1'b0);
    step(0, 32'h0000_0500, 1'b0, 1'b0);
    check("pre_reset_in_flight", pend.size(), 32'd2);
    step(0, 32'h0000_0500, 1'b1, 1'b0);
    ack_pct = 100;
    step(0, 32'h0000_0200, 1'b0, 1'b1);
    check("post_reset_cyc_low", {31'd0, s_cyc}, 32'd0);
    check("post_reset_stb_low", {31'd0, s_stb}, 32'd0);
    check("post_reset_valid_low", {31'd0, s_valid}, 32'd0);
    for (int i = 0; i < 8; i++) step(1, 32'd0, 1'b0, 1'b0);

    // Reset then hold 0: fetch begins at 0 immediately
    step(0, 32'd0, 1'b1, 1'b0);
    step(0, 32'd0, 1'b0, 1'b0);
    check("reset_hold_stb", {31'd0, s_stb}, 32'd1);
    check("reset_hold_adr", s_adr, 32'd0);

    // Randomized traffic: random stalls, ack delays and redirects
    data_sel = 2; ack_pct = 60; stall_pct = 30;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0)      step(0, $urandom & 32'hFFFF_FFFC, 1'b0, 1'b0);
      else if (r == 1) step(0, m_cur + 32'd4, 1'b0, 1'b0);
      else if (r == 2) step(0, m_cur, 1'b0, 1'b0);
      else             step(1, 32'd0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
